// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit adder, one nibble per clock through a single ripple_4bit slice
module ripple_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] f,
  output logic       cout
);
  logic c1, c2, c3;
  logic [3:0] p;

  assign p    = a ^ b;
  assign f[0] = p[0] ^ cin;
  assign c1   = (a[0] & b[0]) | (p[0] & cin);
  assign f[1] = p[1] ^ c1;
  assign c2   = (a[1] & b[1]) | (p[1] & c1);
  assign f[2] = p[2] ^ c2;
  assign c3   = (a[2] & b[2]) | (p[2] & c2);
  assign f[3] = p[3] ^ c3;
  assign cout = (a[3] & b[3]) | (p[3] & c3);
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [3:0]        slice_f;
  logic              slice_cout;
  logic [IDXW+1:0]   bit_base;

  // Nibble idx starts at bit 4*idx; concatenation keeps the index narrow.
  assign bit_base = {idx_q, 2'b00};

  ripple_4bit u_slice (a_q[bit_base +: 4], b_q[bit_base +: 4], carry_q, slice_f, slice_cout);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[bit_base +: 4] = slice_f;
        carry_d              = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder built on one existing ripple_4bit slice.
- Adds one 4-bit nibble per clock, LSB nibble first, and chains the carry through a register.
- Sits directly around ripple_4bit: it feeds the slice's operands and carry-in, and consumes the slice's sum and carry-out.
- Gives a small-area alternative to the wide carry-select path, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands present on a, b, cin.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  WIDTH  registered result, equal to (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry-out of the top nibble.
- busy  output  1  high while in RUN or DONE.

Behaviour:
- Datapath:
  - Exactly one ripple_4bit instance, connected positionally as (A, B, cin, F, cout).
  - Slice inputs are a_reg[4*idx+:4], b_reg[4*idx+:4] and carry_reg.
  - idx is a counter of width clog2(NIB), minimum 1 bit.
  - No "+" operator on operands inside the block; all addition goes through the slice.
- Reset:
  - At a clk edge with rst=1: state=IDLE; idx, carry_reg, a_reg, b_reg, sum and cout all 0; out_valid=0; busy=0.
  - in_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b, cin into a_reg, b_reg, carry_reg; clear idx and sum; go to RUN.
  - cout is cleared at accept.
- FSM RUN:
  - Each edge writes slice F into sum[4*idx+:4] and slice cout into carry_reg.
  - If idx==NIB-1: write slice cout to the cout output and go to DONE. Otherwise increment idx.
  - in_valid is ignored while in RUN.
- FSM DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_ready: go to IDLE and drop out_valid at that edge.
  - in_ready stays 0 in DONE, including the cycle out_ready is high. This gives one bubble; there is no accept in the same cycle as a result handoff.
- Latency and throughput:
  - out_valid rises exactly NIB edges after the accepting edge (4 for WIDTH=16).
  - Minimum spacing between accepts is NIB+2 cycles.
- Wrap-around: an overflow past bit WIDTH-1 appears only on cout; sum wraps mod 2^WIDTH.
- Reset mid-operation: a synchronous rst in RUN or DONE aborts the operation. The result is discarded, out_valid never pulses, and in_ready returns the cycle after rst deasserts.
- out_ready while out_valid=0 has no effect.
- busy = (state!=IDLE).

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1. Required: out_valid rises 4 edges after accept; sum=0x5555, cout=0; in_ready=0 until the edge after the handoff.
- Full carry ripple, a=0xFFFF, b=0x0000, cin=1. Required: sum=0x0000, cout=1. Repeat with a=0xFFFF, b=0x0001, cin=0; same result.
- Backpressure: a=0x8000, b=0x8000, cin=1, out_ready held 0 for 10 cycles. Required: out_valid stays 1; sum=0x0001 and cout=1 stay stable; busy=1; in_ready=0 throughout. Then out_ready=1: IDLE on the next edge.
- Stimulus while busy: hold in_valid=1 with a=0x1111, b=0x1111 during RUN after accepting a=0x000F, b=0x0001, cin=0. Required: result is 0x0010 with cout=0; the second operand pair is accepted only once back in IDLE, and then yields 0x2222.
- Reset: assert rst for one cycle while idx=2 of an operation. Required: the next cycle shows out_valid=0, busy=0, sum=0, cout=0; in_ready=1 one cycle after rst falls; a fresh 0x0001+0x0001 gives 0x0002.
- WIDTH=8 exhaustive check: all a, b in 0..255 and cin in {0,1}. Required: {cout,sum} == a+b+cin for every case, and every out_valid arrives 2 edges after its accept.
